booth_r4_mult_hs: RTL and testbench

- Parametrised, iterative radix-4 Booth multiplier with valid/ready handshakes on operand input and product output.
- Runtime signed/unsigned mode, abort, and a sticky-free done/ready protocol.
- Successor to the radix-4 Booth datapath. Adds its own control FSM, an iteration counter and guard-bit sizing, so ±2M partial products never overflow at any width.
- Sits between operand producers (e.g. the ALU issue stage) and result consumers in the arithmetic subsystem.

---
 rtl/booth_r4_mult_hs.sv | 115 +++++++++++
 tb/tb_booth_r4_mult_hs.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/booth_r4_mult_hs.sv
// Iterative radix-4 Booth multiplier with valid/ready handshakes on operands and product.
// Each BUSY cycle retires two multiplier bits; two guard bits on A keep +/-2M steps exact.
module booth_r4_mult_hs #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   m_in,
  input  logic [DATA_WIDTH-1:0]   q_in,
  input  logic                    is_signed,
  input  logic                    abort,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] product
);

  localparam int ITER  = (DATA_WIDTH + 2) / 2;
  localparam int CNT_W = $clog2(ITER + 1);
  localparam int EW    = DATA_WIDTH + 2;
  localparam int AW    = DATA_WIDTH + 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic signed [AW-1:0] a_q;
  logic signed [EW-1:0] me_q;
  logic [EW-1:0]        q_q;
  logic                 q_prev;
  logic [CNT_W-1:0]     cnt;

  logic                 accept;
  logic                 last_iter;
  logic signed [AW-1:0] me_x;
  logic signed [AW-1:0] a_sum;
  logic signed [AW-1:0] a_nxt;
  logic [EW-1:0]        q_nxt;

  // abort wins over a same-cycle accept
  assign accept    = in_valid && in_ready && !abort;
  assign last_iter = (cnt == CNT_W'(ITER - 1));
  assign me_x      = {{2{me_q[EW-1]}}, me_q};

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      S_IDLE: if (accept) state_nxt = S_BUSY;
      S_BUSY: begin
        if (abort)          state_nxt = S_IDLE;
        else if (last_iter) state_nxt = S_DONE;
      end
      S_DONE: if (out_ready || abort) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    busy      = (state == S_BUSY);
    out_valid = (state == S_DONE);
  end

  // One Booth recoding step on {Q[1],Q[0],q_prev}, then arithmetic shift of {A,Q,q_prev} by 2.
  always_comb begin
    a_sum = a_q;
    unique case ({q_q[1:0], q_prev})
      3'b001, 3'b010: a_sum = a_q + me_x;
      3'b011:         a_sum = a_q + (me_x <<< 1);
      3'b100:         a_sum = a_q - (me_x <<< 1);
      3'b101, 3'b110: a_sum = a_q - me_x;
      default:        a_sum = a_q;
    endcase
    a_nxt = a_sum >>> 2;
    q_nxt = {a_sum[1:0], q_q[EW-1:2]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      me_q    <= '0;
      q_q     <= '0;
      q_prev  <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else if (accept) begin
      me_q   <= is_signed ? {{2{m_in[DATA_WIDTH-1]}}, m_in} : {2'b00, m_in};
      q_q    <= is_signed ? {{2{q_in[DATA_WIDTH-1]}}, q_in} : {2'b00, q_in};
      a_q    <= '0;
      q_prev <= 1'b0;
      cnt    <= '0;
    end else if (state == S_BUSY && !abort) begin
      a_q    <= a_nxt;
      q_q    <= q_nxt;
      q_prev <= q_q[1];
      cnt    <= cnt + CNT_W'(1);
      // After the final step Q holds the low EW product bits, A the rest
      if (last_iter) product <= {a_nxt[DATA_WIDTH-3:0], q_nxt};
    end
  end

endmodule

// File: tb/tb_booth_r4_mult_hs.sv
// Bench for booth_r4_mult_hs: directed vectors plus a random stream, checked against
// an integer-multiply scoreboard that tracks accepted, aborted and delivered operations.
module tb_booth_r4_mult_hs;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   m_in;
  logic [W-1:0]   q_in;
  logic           is_signed;
  logic           abort;
  logic           busy;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;

  int n_vec = 0;
  int n_mis = 0;
  int accept_cnt = 0;
  int done_cnt = 0;
  int acc0, done0, s_base, s_t;
  logic stream_done;
  logic [2*W-1:0] exp_q[$];

  booth_r4_mult_hs #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .m_in      (m_in),
    .q_in      (q_in),
    .is_signed (is_signed),
    .abort     (abort),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [2*W-1:0] model(input logic [W-1:0] m, input logic [W-1:0] q,
                                           input logic s);
    longint a, b, p;
    a = s ? longint'($signed(m)) : longint'({48'd0, m});
    b = s ? longint'($signed(q)) : longint'({48'd0, q});
    p = a * b;
    return p[2*W-1:0];
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Scoreboard bookkeeping on the active edge
  always @(negedge rst_n) exp_q.delete();

  always @(posedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready && !abort) begin
        exp_q.push_back(model(m_in, q_in, is_signed));
        accept_cnt++;
      end
      if ((busy && abort) || (out_valid && (out_ready || abort))) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (out_valid && out_ready) done_cnt++;
      end
    end
  end

  // Compare process: every cycle the product is valid, plus a state sanity check
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) check("sb_empty", 1, 0);
        else                   check("sb_product", product, exp_q[0]);
      end
      check("one_state", $countones({in_ready, busy, out_valid}), 1);
    end
  end

  task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q, input logic s,
                        input int hold, input logic [2*W-1:0] exp, input string tag);
    int lat, bcnt, a0;
    @(negedge clk);
    check({tag, "_rdy"}, in_ready, 1);
    m_in = m; q_in = q; is_signed = s; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; m_in = '1; q_in = '1; is_signed = ~s;
    lat = 0; bcnt = 0;
    while (!out_valid && lat < 40) begin
      if (busy) bcnt++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, "_lat"}, lat, 9);
    check({tag, "_busy"}, bcnt, 9);
    check({tag, "_prod"}, product, exp);
    a0 = accept_cnt;
    repeat (hold) begin
      in_valid = 1'b1; m_in = 16'h0003; q_in = 16'h0003; is_signed = 1'b0;
      @(negedge clk);
      check({tag, "_hold_v"}, out_valid, 1);
      check({tag, "_hold_r"}, in_ready, 0);
      check({tag, "_hold_p"}, product, exp);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_idle_r"}, in_ready, 1);
    check({tag, "_idle_v"}, out_valid, 0);
    check({tag, "_keep"}, product, exp);
    check({tag, "_nocap"}, accept_cnt, a0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; m_in = '0; q_in = '0; is_signed = 1'b0;
    abort = 1'b0; out_ready = 1'b0; stream_done = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_product", product, 0);
    rst_n = 1'b1;

    // Hand-computed values pinning the reference model
    check("mdl_neg3x7", model(16'hFFFD, 16'h0007, 1'b1), 32'hFFFFFFEB);
    check("mdl_uffff", model(16'hFFFF, 16'hFFFF, 1'b0), 32'hFFFE0001);
    check("mdl_s8000x7fff", model(16'h8000, 16'h7FFF, 1'b1), 32'hC0008000);

    run_op(16'hFFFD, 16'h0007, 1'b1, 0, 32'hFFFFFFEB, "neg3x7");
    run_op(16'h8000, 16'h8000, 1'b1, 0, 32'h40000000, "s_min_min");
    run_op(16'h8000, 16'h7FFF, 1'b1, 0, 32'hC0008000, "s_min_max");
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 0, 32'hFFFE0001, "u_max_max");
    run_op(16'h8000, 16'h0002, 1'b0, 0, 32'h00010000, "u_8000x2");
    run_op(16'h8000, 16'h0002, 1'b1, 0, 32'hFFFF0000, "s_8000x2");
    run_op(16'h1234, 16'h0010, 1'b0, 5, 32'h00012340, "bp");

    // Abort on the edge that would perform iteration 4
    @(negedge clk);
    m_in = 16'h00FF; q_in = 16'h00FF; is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_rdy", in_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_prod", product, 32'h00012340);
    repeat (12) begin
      @(negedge clk);
      check("abort_noval", out_valid, 0);
    end

    // abort in IDLE blocks a same-cycle accept
    acc0 = accept_cnt;
    in_valid = 1'b1; abort = 1'b1; m_in = 16'h0009; q_in = 16'h0009;
    @(negedge clk);
    in_valid = 1'b0; abort = 1'b0;
    check("idle_abort_acc", accept_cnt, acc0);
    check("idle_abort_busy", busy, 0);

    run_op(16'h0005, 16'h0006, 1'b1, 0, 32'h0000001E, "s5x6");

    // Async reset in the middle of an operation
    @(negedge clk);
    m_in = 16'h0007; q_in = 16'h0009; is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_product", product, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back random stream with random output backpressure
    acc0 = accept_cnt;
    done0 = done_cnt;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          m_in = W'($urandom); q_in = W'($urandom); is_signed = 1'($urandom_range(0, 1));
          in_valid = 1'b1;
          s_base = accept_cnt; s_t = 0;
          while (accept_cnt == s_base && s_t < 200) begin
            @(negedge clk);
            s_t++;
          end
          in_valid = 1'b0;
          if (s_t >= 200) check("stream_accept_timeout", s_t, 0);
        end
        s_t = 0;
        while (exp_q.size() > 0 && s_t < 400) begin
          @(negedge clk);
          s_t++;
        end
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(negedge clk);
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b0;
      end
    join
    check("stream_accepted", accept_cnt - acc0, 100);
    check("stream_delivered", done_cnt - done0, 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
